// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute-stage control and the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, op, start,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  a, b, op, start,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave io
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: upper product half / partial remainder; sh: multiplier-then-low-product / dividend-then-quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_abs     = (io.op[0] && io.a[WIDTH-1]) ? -io.a : io.a;
  assign b_abs     = (io.op[0] && io.b[WIDTH-1]) ? -io.b : io.b;
  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
  assign div_shift = {acc_q, sh_q[WIDTH-1]};
  // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag.
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign prod      = {acc_q, sh_q};
  assign prod_fix  = res_neg_q ? -prod : prod;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          if (!io.op[2]) begin
            state_d   = RUN;
            busy_d    = 1'b1;
            cnt_d     = CW'(WIDTH);
            is_div_d  = io.op[1];
            res_neg_d = io.op[0] & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
            rem_neg_d = io.op[0] & io.a[WIDTH-1];
            dz_d      = io.op[1] && (io.b == '0);
            acc_d     = '0;
            sh_d      = io.op[1] ? a_abs : b_abs;
            opb_d     = io.op[1] ? b_abs : a_abs;
          end else if (io.op[1:0] == 2'b00) begin
            hi_d = io.a;
          end else if (io.op[1:0] == 2'b01) begin
            lo_d = io.a;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div_zero_d = is_div_q & dz_q;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (!dz_q) begin
          lo_d = res_neg_q ? -sh_q : sh_q;
          hi_d = rem_neg_q ? -acc_q : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.div_zero = div_zero_q;
  assign io.hi       = hi_q;
  assign io.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .io(bus));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(bus8));

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural model: results from plain integer arithmetic, applied WIDTH+1 edges after accept.
  bit          m_busy = 0, m_done = 0, m_dz = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi, p_lo;
  bit          p_dz;
  int          remain = 0;

  task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    logic [63:0] up;
    longint      sp;
    int          sa, sb;
    dz = 1'b0; rh = '0; rl = '0;
    sa = a; sb = b;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; rh = up[63:32]; rl = up[31:0]; end
      3'd2: if (b == 0) dz = 1'b1; else begin rl = a / b; rh = a % b; end
      3'd3: begin
        if (b == 0) dz = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = a; rh = '0; end
        else begin rl = sa / sb; rh = sa % sb; end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dz   = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_hi = '0; m_lo = '0; remain = 0;
    end else if (m_busy) begin
      remain--;
      if (remain == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_dz = p_dz;
        if (!p_dz) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (bus.start) begin
      if (!bus.op[2]) begin
        model_result(bus.op, bus.a, bus.b, p_hi, p_lo, p_dz);
        m_busy = 1'b1; remain = 33;
      end else if (bus.op == 3'd4) m_hi = bus.a;
      else if (bus.op == 3'd5) m_lo = bus.a;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("div_zero", bus.div_zero, m_dz);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (!bus.done && cyc < 100) begin
      if (bus.busy) nb++;
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", cyc < 100, 1'b1);
  endtask

  int cyc, nb, ndone;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  initial begin
    bus.a = '0; bus.b = '0; bus.op = '0; bus.start = 1'b0;
    bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.start = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_hi", bus.hi, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;

    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, nb);
    check("multu_latency", cyc, 33);
    check("multu_busy_cycles", nb, 33);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);
    check("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, nb);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, nb);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    check("model_div_lo", m_lo, 32'hFFFF_FFFD);

    issue(3'd2, 32'd100, 32'd7);
    wait_done(cyc, nb);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    issue(3'd4, 32'h1234, 32'd0);
    check("mthi", bus.hi, 32'h1234);
    check("mthi_busy", bus.busy, 0);
    issue(3'd5, 32'h5678, 32'd0);
    check("mtlo", bus.lo, 32'h5678);

    issue(3'd2, 32'd5, 32'd0);
    wait_done(cyc, nb);
    check("dz_latency", cyc, 33);
    check("dz_flag", bus.div_zero, 1);
    check("dz_hi_kept", bus.hi, 32'h1234);
    check("dz_lo_kept", bus.lo, 32'h5678);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, nb);
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'h0);
    check("ovf_dz", bus.div_zero, 0);

    issue(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(3'd0, 32'd2, 32'd3);
    wait_done(cyc, nb);
    check("ignored_lo", bus.lo, 32'd14);
    check("ignored_hi", bus.hi, 32'd2);
    issue(3'd0, 32'd2, 32'd3);
    wait_done(cyc, nb);
    check("b2b_latency", cyc, 33);
    check("b2b_hi", bus.hi, 32'd0);
    check("b2b_lo", bus.lo, 32'd6);

    issue(3'd2, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("rst_no_done", ndone, 0);

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       r_b = 32'd0;
        1:       r_b = 32'hFFFF_FFFF;
        2, 3, 4: r_b = $urandom_range(1, 20);
        default: r_b = $urandom;
      endcase
      issue(r_op, r_a, r_b);
      if (!r_op[2]) wait_done(cyc, nb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    bus8.a = 8'h80; bus8.b = 8'h80; bus8.op = 3'd1; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 0;
    while (!bus8.done && cyc < 50) begin @(negedge clk); cyc++; end
    check("w8_latency", cyc, 9);
    check("w8_mult_hi", bus8.hi, 8'h40);
    check("w8_mult_lo", bus8.lo, 8'h00);
    bus8.a = 8'hFF; bus8.b = 8'h10; bus8.op = 3'd2; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    cyc = 0;
    while (!bus8.done && cyc < 50) begin @(negedge clk); cyc++; end
    check("w8_divu_latency", cyc, 9);
    check("w8_divu_lo", bus8.lo, 8'h0F);
    check("w8_divu_hi", bus8.hi, 8'h0F);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the MIPS datapath, sitting beside the single-cycle ALU in the execute stage. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and owns the architectural HI/LO registers, including the MTHI/MTLO writes. A start/busy/done handshake lets the pipeline control stall dependent instructions until the result is ready.

## Interface
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Legal for WIDTH ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt operand: multiplier or divisor.
- op  in  3  operation select:
  - 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- start  in  1  request; sampled only while busy=0.
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  one-cycle pulse when an iterative operation completes.
- div_zero  out  1  valid with done; 1 means the divisor was zero.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

## Operation
- States:
  - IDLE: accepts start.
  - RUN: iterates for WIDTH cycles, with a down-counter of width clog2(WIDTH+1).
  - FIX: applies sign correction, writes results, pulses done; next state is IDLE.
- Accept in IDLE (start=1):
  - op 00x or 01x: latch operands and go to RUN. Signed ops latch absolute values, result-sign = a[W-1]^b[W-1] and remainder-sign = a[W-1].
  - op 100: hi←a at that edge. op 101: lo←a at that edge. Neither sets busy or pulses done.
  - op 11x: ignored.
- Multiply: shift-add over the 2·WIDTH-bit product {hi_acc, lo_acc}. In FIX, negate the product if result-sign is set. Then hi←product[2W-1:W] and lo←product[W-1:0].
- Divide: restoring division, one quotient bit per cycle. In FIX, lo←quotient and hi←remainder. Quotient is negated if result-sign is set; remainder is negated if remainder-sign is set. Remainder sign follows the dividend.
- Divide by zero (b=0 at accept):
  - Still runs the full latency.
  - hi and lo are NOT written.
  - div_zero=1 in the done cycle.
- Signed overflow, DIV of most-negative by −1: lo←most-negative, hi←0. No flag.
- start while busy=1 is ignored; operands and op are not re-sampled.
- hi and lo keep their old values throughout RUN/FIX until the FIX edge.
- rst in any state:
  - state←IDLE; busy, done, div_zero←0; hi, lo←0.
  - The in-flight result is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0.
- Let E0 be the accepting edge.
  - busy=1 from after E0 through the cycle ending at edge E(WIDTH+1).
  - hi/lo update at E(WIDTH+1).
  - done=1 and busy=0 during the cycle after E(WIDTH+1).
- Latency is WIDTH+1 cycles from accept to result: 33 cycles for WIDTH=32.
- A new start may be accepted in the done cycle. That start's own done follows exactly WIDTH+1 cycles later.
- MTHI/MTLO are single-cycle: the new value is visible the cycle after the accepting edge.
- done, div_zero and busy are registered outputs with no combinational path from inputs.

## Test plan
- Unsigned multiply, WIDTH=32: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done asserts exactly 33 cycles after the accept edge; busy is high for 33 cycles.
- Signed multiply and divide:
  - MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
- Corner cases:
  - MTHI 0x1234 then MTLO 0x5678 → values visible next cycle.
  - Then DIVU a=5, b=0 → done=1, div_zero=1, hi=0x1234, lo=0x5678 unchanged.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Handshake:
  - A second start (MULTU 2×3) issued 5 cycles into a DIVU is ignored: the result is the DIVU's.
  - A MULTU 2×3 issued in the done cycle is accepted → hi=0, lo=6 after 33 more cycles.
- Reset mid-operation: assert rst at cycle 10 of a DIVU 100/7 → next cycle busy=0, hi=lo=0, and no done pulse ever appears for that op.
- Parametrisation: WIDTH=8 instance, MULT a=0x80, b=0x80 → hi=0x40, lo=0x00, latency 9 cycles. DIVU a=0xFF, b=0x10 → lo=0x0F, hi=0x0F.
